// File: rtl/ctrl_decode_seq_pkg.sv
// Shared decode definitions: opcodes, funct7 codes, FSM states, control bundle.
// M_EXT_EN selects whether funct7=0000001 R-types decode as MUL/DIV.
package ctrl_decode_seq_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ARITH = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_CSR   = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  localparam logic [4:0] IMM_I = 5'b10000;
  localparam logic [4:0] IMM_S = 5'b01000;
  localparam logic [4:0] IMM_B = 5'b00100;
  localparam logic [4:0] IMM_J = 5'b00010;
  localparam logic [4:0] IMM_U = 5'b00001;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_sext;
    logic       unc_branch;
    logic       pc_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [1:0] alu_a_src;
    logic [1:0] alu_b_src;
    logic [3:0] mem_write;
    logic [4:0] imm_type;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Combinational opcode/funct decode table for the decode stage.
// M_EXT_EN enables recognition of MUL/DIV (funct7=0000001).
module ctrl_decode_comb
  import ctrl_decode_seq_pkg::*;
#(
  parameter int TRIM_W = 2
) (
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  output ctrl_t             ctrl_o,
  output logic [TRIM_W-1:0] trim_o,
  output logic              illegal_o,
  output logic              is_md_o
);

  logic md_f7;
  logic r_ok;

`ifdef M_EXT_EN
  assign md_f7 = (funct7_i == F7_MD);
`else
  assign md_f7 = 1'b0;
`endif

  assign r_ok = (funct7_i == F7_BASE)
              | (funct7_i == F7_ALT)
              | md_f7;

  always_comb begin
    ctrl_o    = '0;
    trim_o    = '0;
    illegal_o = 1'b0;
    is_md_o   = 1'b0;
    unique case (1'b1)
      (opcode_i == OP_R): begin
        if (r_ok) begin
          ctrl_o.alu_op    = 2'b10;
          ctrl_o.reg_write = 1'b1;
          is_md_o          = md_f7;
        end else begin
          illegal_o = 1'b1;
        end
      end
      (opcode_i == OP_LOAD): begin
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_b_src  = 2'b01;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.imm_type   = IMM_I;
        if (funct3_i[1]) begin
          ctrl_o.mem_sext = 1'b1;
        end else begin
          ctrl_o.mem_sext = ~funct3_i[2];
          trim_o = funct3_i[0] ? TRIM_W'(2'b01)
                               : TRIM_W'(2'b10);
        end
      end
      (opcode_i == OP_ARITH): begin
        ctrl_o.alu_op    = 2'b11;
        ctrl_o.alu_b_src = 2'b01;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.imm_type  = IMM_I;
      end
      (opcode_i == OP_S): begin
        ctrl_o.alu_b_src = 2'b01;
        ctrl_o.imm_type  = IMM_S;
        if (funct3_i[1])      ctrl_o.mem_write = 4'b1111;
        else if (funct3_i[0]) ctrl_o.mem_write = 4'b0011;
        else                  ctrl_o.mem_write = 4'b0001;
      end
      (opcode_i == OP_B): begin
        ctrl_o.alu_op   = 2'b01;
        ctrl_o.imm_type = IMM_B;
      end
      (opcode_i == OP_JAL): begin
        ctrl_o.alu_a_src  = 2'b01;
        ctrl_o.alu_b_src  = 2'b10;
        ctrl_o.unc_branch = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.imm_type   = IMM_J;
      end
      (opcode_i == OP_JALR): begin
        ctrl_o.alu_a_src  = 2'b01;
        ctrl_o.alu_b_src  = 2'b10;
        ctrl_o.unc_branch = 1'b1;
        ctrl_o.pc_src     = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.imm_type   = IMM_I;
      end
      (opcode_i == OP_LUI): begin
        ctrl_o.alu_a_src = 2'b10;
        ctrl_o.alu_b_src = 2'b01;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.imm_type  = IMM_U;
      end
      (opcode_i == OP_AUIPC): begin
        ctrl_o.alu_a_src = 2'b01;
        ctrl_o.alu_b_src = 2'b01;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.imm_type  = IMM_U;
      end
      (opcode_i == OP_CSR): begin
        ctrl_o.imm_type = IMM_I;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_decode_seq.sv
// Decode stage: registered control bundle, handshake and MUL/DIV hold FSM.
// M_EXT_EN enables MUL/DIV issue (md_op_o/md_start_o tied 0 otherwise).
module ctrl_decode_seq
  import ctrl_decode_seq_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int TRIM_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic              mem_read_o,
  output logic              mem_to_reg_o,
  output logic              mem_sign_extend_o,
  output logic              unc_branch_o,
  output logic              pc_adder_src_o,
  output logic              reg_write_o,
  output logic [TRIM_W-1:0] mem_trim_o,
  output logic [1:0]        alu_op_o,
  output logic [1:0]        alu_a_src_o,
  output logic [1:0]        alu_b_src_o,
  output logic [3:0]        mem_write_o,
  output logic [4:0]        imm_gen_type_o,
  output logic [2:0]        md_op_o,
  output logic              md_start_o,
  output logic              illegal_o
);

  localparam int         CNT_W    = $clog2(MD_LAT + 1);
  localparam bit         MD_MULTI = (MD_LAT > 1);
  localparam [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);
  localparam [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ctrl_t             dec_ctrl;
  logic [TRIM_W-1:0] dec_trim;
  logic              dec_ill;
  logic              dec_md;
  logic              accept;

  ctrl_t             ctrl_q, ctrl_d;
  logic [TRIM_W-1:0] trim_q, trim_d;
  logic              valid_q, valid_d;
  logic              ill_q, ill_d;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  ctrl_decode_comb #(
    .TRIM_W (TRIM_W)
  ) u_dec (
    .opcode_i  (opcode_i),
    .funct3_i  (funct3_i),
    .funct7_i  (funct7_i),
    .ctrl_o    (dec_ctrl),
    .trim_o    (dec_trim),
    .illegal_o (dec_ill),
    .is_md_o   (dec_md)
  );

  assign ready_o = ~stall_i & (state_q == S_IDLE);
  assign accept  = valid_i & ready_o & ~flush_i;

  always_comb begin
    ctrl_d  = ctrl_q;
    trim_d  = trim_q;
    valid_d = valid_q;
    ill_d   = ill_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      ctrl_d  = '0;
      trim_d  = '0;
      valid_d = 1'b0;
      ill_d   = 1'b0;
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) state_d = S_IDLE;
    end else if (accept) begin
      ctrl_d  = dec_ctrl;
      trim_d  = dec_trim;
      valid_d = 1'b1;
      ill_d   = dec_ill;
      if (dec_md && MD_MULTI) begin
        state_d = S_BUSY;
        cnt_d   = CNT_LOAD;
      end
    end else begin
      ctrl_d  = '0;
      trim_d  = '0;
      valid_d = 1'b0;
      ill_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q  <= '0;
      trim_q  <= '0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      trim_q  <= trim_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef M_EXT_EN
  logic [2:0] md_op_q, md_op_d;
  logic       md_start_q, md_start_d;

  // Start pulses only on the accepting edge; BUSY keeps md_op stable.
  always_comb begin
    md_start_d = accept & dec_md;
    md_op_d    = md_op_q;
    if (flush_i)                    md_op_d = '0;
    else if (state_q == S_BUSY)     md_op_d = md_op_q;
    else if (accept && dec_md)      md_op_d = funct3_i;
    else                            md_op_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      md_op_q    <= '0;
      md_start_q <= 1'b0;
    end else begin
      md_op_q    <= md_op_d;
      md_start_q <= md_start_d;
    end
  end

  assign md_op_o    = md_op_q;
  assign md_start_o = md_start_q;
`else
  assign md_op_o    = '0;
  assign md_start_o = 1'b0;
`endif

  assign valid_o           = valid_q;
  assign illegal_o         = ill_q;
  assign mem_read_o        = ctrl_q.mem_read;
  assign mem_to_reg_o      = ctrl_q.mem_to_reg;
  assign mem_sign_extend_o = ctrl_q.mem_sext;
  assign unc_branch_o      = ctrl_q.unc_branch;
  assign pc_adder_src_o    = ctrl_q.pc_src;
  assign reg_write_o       = ctrl_q.reg_write;
  assign mem_trim_o        = trim_q;
  assign alu_op_o          = ctrl_q.alu_op;
  assign alu_a_src_o       = ctrl_q.alu_a_src;
  assign alu_b_src_o       = ctrl_q.alu_b_src;
  assign mem_write_o       = ctrl_q.mem_write;
  assign imm_gen_type_o    = ctrl_q.imm_type;

endmodule
